op_mode_dec: RTL and testbench
==============================

# op_mode_dec

Post-KHAZAD chaining stage for the cipher datapath. It sits between the KHAZAD core output and the block output. It also keeps the chaining state that the pre-KHAZAD XOR stage needs: the previous cipher output (`Cminus1`) and the `first_block` flag. In CBC decryption it XORs each core output with the IV or with the previous ciphertext block, which it buffers on the way into the core. In ECB mode and in CBC encryption it passes core output through a registered valid/ready stage.

## Interface
Parameters:
- `CHAIN_DEPTH`, default 2: ciphertext FIFO depth, i.e. the number of blocks that may be in flight inside the core. Power of 2, ≥ 1.

Ports:
- `clk`  in  1  single clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op_mode`  in  1  0: ECB, 1: CBC. Held stable per message.
- `enc_dec_SEL`  in  1  0: decrypt, 1: encrypt. Held stable per message.
- `IV`  in  64  initialization vector, sampled when the first block's output is produced.
- `msg_start`  in  1  one-cycle pulse; the next block is the first block of a new message.
- `ct_valid`  in  1  a block is entering the core (this stage's FIFO push request).
- `ct_in`  in  64  block entering the core.
- `ct_ready`  out  1  FIFO can accept; the upstream must not launch the core when this is low.
- `core_valid`  in  1  KHAZAD output valid.
- `core_out`  in  64  KHAZAD output.
- `core_ready`  out  1  this stage accepts `core_out`.
- `d_out`  out  64  result block.
- `d_out_valid`  out  1  `d_out` valid.
- `d_out_ready`  in  1  downstream accepts.
- `Cminus1`  out  64  last accepted core output, used by the pre-KHAZAD stage.
- `first_block`  out  1  1 until the first block of the current message has been accepted from the core.

## Operation
- Push condition: FIFO push occurs on `ct_valid && ct_ready`, and only when `op_mode=1 && enc_dec_SEL=0`; otherwise `ct_in` is ignored.
- Accept condition: a core output is accepted on `core_valid && core_ready`, where `core_ready = !d_out_valid || d_out_ready`.
- Accept in CBC decryption:
  - The FIFO pops the head `C_i`.
  - `d_out <= core_out ^ (first_block ? IV : prev_ct)`.
  - `prev_ct <= C_i`.
- Accept in ECB mode or CBC encryption: `d_out <= core_out`.
- Every accept, all modes: `Cminus1 <= core_out`, `first_block <= 0`, `d_out_valid <= 1`.
- Output hold: `d_out_valid` clears on `d_out_ready` when there is no simultaneous accept. `d_out` is stable while valid and not ready.
- Two-state FSM:
  - FIRST: `first_block=1`.
  - CHAIN: `first_block=0`.
  - FIRST → CHAIN on accept.
  - Any state → FIRST on `msg_start`.
- `msg_start`:
  - Flushes the FIFO and `prev_ct`.
  - Does not cancel a pending `d_out`.
  - If it coincides with an accept, `msg_start` wins for the FSM, so the state is FIRST. The accepted block still uses the pre-`msg_start` `first_block` value.
- FIFO boundaries:
  - Full: `ct_ready=0`.
  - Simultaneous push and pop when full: allowed. The pop frees the slot in the same cycle, so `ct_ready = !full || pop`.
  - Empty with a CBC-decrypt accept: protocol error. `d_out` uses 0 in place of the head entry, and the FIFO pointers do not move.

## Timing
- Reset values: `d_out=0`, `d_out_valid=0`, `Cminus1=0`, `first_block=1`, FIFO empty, `ct_ready=1`, `prev_ct=0`.
- Latency: one cycle from accept to `d_out_valid`. Back-to-back accepts are sustained at one per cycle when `d_out_ready=1`.
- `ct_ready` and `core_ready` are combinational from state and `d_out_ready`. No combinational path from `core_out` to `d_out`.
- Reset asserted mid-message returns every register to its reset value immediately. In-flight core blocks are lost.

## Structure
- Shared package: `OP_ECB=0`, `OP_CBC=1`, `DIR_DEC=0`, `DIR_ENC=1`, `BLK_W=64`, and the FSM state encoding.
- One sub-module, `chain_fifo`: a synchronous FIFO with width `BLK_W` and depth `CHAIN_DEPTH`, providing push, pop, full, empty and flush.

## Test plan
- ECB decrypt: core outputs 0x0123456789ABCDEF, then 0xFEDCBA9876543210 → `d_out` equals them; FIFO stays empty; `first_block` is 1 → 0 after the first block.
- CBC decrypt, 3 blocks:
  - Setup: IV=0x1111111111111111; pushes C1=0xAAAA…, C2=0x5555…, C3=0x0F0F…; core outputs X1..X3.
  - Required `d_out`: X1^IV, X2^C1, X3^C2.
- CBC encrypt: core outputs 0xDEADBEEFDEADBEEF → `Cminus1` equals it on the next cycle; `d_out` passes through; `first_block=0`.
- Backpressure: `d_out_ready=0` for 5 cycles with a pending block → `d_out` stable, `core_ready=0`, and the FIFO fills to `CHAIN_DEPTH` with `ct_ready=0`. On release, outputs drain in order.
- `msg_start` mid-message after 2 blocks → FIFO flushed, `first_block=1`; the next block uses the new IV.
- Reset mid-stream (`rst_n` low for 1 cycle with the FIFO holding 2 entries) → all outputs at reset values asynchronously; the FIFO is empty afterwards.

Source files
------------

// File: rtl/op_mode_dec_pkg.sv
// Shared constants and FSM encoding for the post-KHAZAD chaining stage.
package op_mode_dec_pkg;

  localparam logic OP_ECB  = 1'b0;
  localparam logic OP_CBC  = 1'b1;
  localparam logic DIR_DEC = 1'b0;
  localparam logic DIR_ENC = 1'b1;
  localparam int   BLK_W   = 64;

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_CHAIN = 1'b1
  } state_t;

endpackage

// File: rtl/op_mode_dec_chain_fifo.sv
// Ciphertext FIFO holding blocks in flight inside the core; flush restarts it
// empty but still takes a push arriving in the same cycle.
module op_mode_dec_chain_fifo
  import op_mode_dec_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [BLK_W-1:0] din,
  output logic [BLK_W-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [BLK_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, wr_addr;
  logic [CNT_W-1:0] count_reg;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign head    = mem[rd_ptr_reg];
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (flush || !full || do_pop);
  assign wr_addr = flush ? '0 : wr_ptr_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_addr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= do_push ? next_ptr('0) : '0;
      count_reg  <= do_push ? CNT_W'(1) : '0;
    end else begin
      if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/op_mode_dec.sv
// Post-KHAZAD chaining stage: CBC-decrypt XOR with IV / previous ciphertext,
// registered valid/ready output, and chaining state for the pre-KHAZAD stage.
module op_mode_dec
  import op_mode_dec_pkg::*;
#(
  parameter int CHAIN_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_mode,
  input  logic             enc_dec_SEL,
  input  logic [BLK_W-1:0] IV,
  input  logic             msg_start,
  input  logic             ct_valid,
  input  logic [BLK_W-1:0] ct_in,
  output logic             ct_ready,
  input  logic             core_valid,
  input  logic [BLK_W-1:0] core_out,
  output logic             core_ready,
  output logic [BLK_W-1:0] d_out,
  output logic             d_out_valid,
  input  logic             d_out_ready,
  output logic [BLK_W-1:0] Cminus1,
  output logic             first_block
);

  state_t           state_reg, state_next;
  logic [BLK_W-1:0] d_out_reg, cminus1_reg, prev_ct_reg;
  logic             d_out_valid_reg;
  logic             cbc_dec, accept, pop_req, push;
  logic             fifo_full, fifo_empty;
  logic [BLK_W-1:0] fifo_head, head_blk, chain_val;

  assign cbc_dec    = (op_mode == OP_CBC) && (enc_dec_SEL == DIR_DEC);
  assign core_ready = !d_out_valid_reg || d_out_ready;
  assign accept     = core_valid && core_ready;
  assign pop_req    = accept && cbc_dec;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign ct_ready   = !fifo_full || pop_req;
  assign push       = ct_valid && ct_ready && cbc_dec;

  // Empty FIFO on a CBC-decrypt accept is a protocol error: chain with zero.
  assign head_blk  = fifo_empty ? '0 : fifo_head;
  assign chain_val = first_block ? IV : prev_ct_reg;

  op_mode_dec_chain_fifo #(
    .DEPTH(CHAIN_DEPTH)
  ) chain_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (msg_start),
    .push  (push),
    .pop   (pop_req),
    .din   (ct_in),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_FIRST;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (msg_start)   state_next = ST_FIRST;
    else if (accept) state_next = ST_CHAIN;
  end

  always_comb begin
    first_block = (state_reg == ST_FIRST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_out_reg       <= '0;
      d_out_valid_reg <= 1'b0;
      cminus1_reg     <= '0;
      prev_ct_reg     <= '0;
    end else begin
      if (accept) begin
        d_out_reg       <= cbc_dec ? (core_out ^ chain_val) : core_out;
        d_out_valid_reg <= 1'b1;
        cminus1_reg     <= core_out;
      end else if (d_out_ready) begin
        d_out_valid_reg <= 1'b0;
      end
      if (msg_start)    prev_ct_reg <= '0;
      else if (pop_req) prev_ct_reg <= head_blk;
    end
  end

  assign d_out       = d_out_reg;
  assign d_out_valid = d_out_valid_reg;
  assign Cminus1     = cminus1_reg;

endmodule

// File: tb/tb_op_mode_dec.sv
// Directed self-checking bench for op_mode_dec (CHAIN_DEPTH=2).
module tb_op_mode_dec;
  import op_mode_dec_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             op_mode, enc_dec_SEL, msg_start;
  logic [BLK_W-1:0] IV, ct_in, core_out;
  logic             ct_valid, core_valid, d_out_ready;
  logic             ct_ready, core_ready, d_out_valid, first_block;
  logic [BLK_W-1:0] d_out, Cminus1;

  int checks   = 0;
  int failures = 0;

  localparam logic [63:0] IV1 = 64'h1111111111111111;
  localparam logic [63:0] IV2 = 64'h2468ACE013579BDF;
  localparam logic [63:0] IV3 = 64'h3333333333333333;
  localparam logic [63:0] C1  = 64'hAAAAAAAAAAAAAAAA;
  localparam logic [63:0] C2  = 64'h5555555555555555;
  localparam logic [63:0] C3  = 64'h0F0F0F0F0F0F0F0F;
  localparam logic [63:0] C4  = 64'h7777000077770000;
  localparam logic [63:0] D1  = 64'h0000FFFF0000FFFF;
  localparam logic [63:0] X1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] X2  = 64'h1122334455667788;
  localparam logic [63:0] X3  = 64'hCAFEBABE00000001;
  localparam logic [63:0] E2  = 64'hFEDCBA9876543210;
  localparam logic [63:0] DB  = 64'hDEADBEEFDEADBEEF;
  localparam logic [63:0] Y1  = 64'h0102030405060708;
  localparam logic [63:0] Y2  = 64'h8070605040302010;
  localparam logic [63:0] Y3  = 64'h00000000DEADBEEF;

  op_mode_dec #(.CHAIN_DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_mode     (op_mode),
    .enc_dec_SEL (enc_dec_SEL),
    .IV          (IV),
    .msg_start   (msg_start),
    .ct_valid    (ct_valid),
    .ct_in       (ct_in),
    .ct_ready    (ct_ready),
    .core_valid  (core_valid),
    .core_out    (core_out),
    .core_ready  (core_ready),
    .d_out       (d_out),
    .d_out_valid (d_out_valid),
    .d_out_ready (d_out_ready),
    .Cminus1     (Cminus1),
    .first_block (first_block)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_msg(input logic mode, input logic dir, input logic [63:0] iv);
    op_mode     = mode;
    enc_dec_SEL = dir;
    IV          = iv;
    msg_start   = 1'b1;
    cycle();
    msg_start   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; op_mode = 1'b0; enc_dec_SEL = 1'b0; msg_start = 1'b0;
    IV = '0; ct_in = '0; core_out = '0; ct_valid = 1'b0; core_valid = 1'b0;
    d_out_ready = 1'b1;
    cycle(); cycle();
    chk("rst_d_out", d_out, 64'h0);
    chk("rst_valid", d_out_valid, 64'h0);
    chk("rst_cminus1", Cminus1, 64'h0);
    chk("rst_first", first_block, 64'h1);
    chk("rst_ct_ready", ct_ready, 64'h1);
    chk("rst_core_ready", core_ready, 64'h1);
    rst_n = 1'b1;
    cycle();

    // ECB decrypt: pass-through, pushes ignored
    start_msg(OP_ECB, DIR_DEC, IV1);
    chk("ecb_first_before", first_block, 64'h1);
    ct_valid = 1'b1; ct_in = C1; core_valid = 1'b1; core_out = X1;
    cycle();
    chk("ecb_d1", d_out, X1);
    chk("ecb_v1", d_out_valid, 64'h1);
    chk("ecb_first_after", first_block, 64'h0);
    core_out = E2;
    cycle();
    chk("ecb_d2", d_out, E2);
    core_valid = 1'b0;
    cycle();
    ct_valid = 1'b0;
    chk("ecb_valid_clear", d_out_valid, 64'h0);
    chk("ecb_fifo_empty", ct_ready, 64'h1);

    // CBC decrypt, 3 blocks, including push+pop while full
    start_msg(OP_CBC, DIR_DEC, IV1);
    ct_valid = 1'b1; ct_in = C1; cycle();
    ct_in = C2; cycle();
    ct_valid = 1'b0; #1;
    chk("cbc_full_ready", ct_ready, 64'h0);
    ct_valid = 1'b1; ct_in = C3; core_valid = 1'b1; core_out = X1; #1;
    chk("cbc_full_pop_ready", ct_ready, 64'h1);
    cycle();
    ct_valid = 1'b0;
    chk("cbc_d1", d_out, X1 ^ IV1);
    core_out = X2; cycle();
    chk("cbc_d2", d_out, X2 ^ C1);
    core_out = X3; cycle();
    chk("cbc_d3", d_out, X3 ^ C2);
    chk("cbc_cminus1", Cminus1, X3);
    core_valid = 1'b0; cycle();
    chk("cbc_drained_ready", ct_ready, 64'h1);

    // CBC encrypt
    start_msg(OP_CBC, DIR_ENC, IV1);
    core_valid = 1'b1; core_out = DB; ct_valid = 1'b1; ct_in = C1;
    cycle();
    core_valid = 1'b0; ct_valid = 1'b0;
    chk("enc_cminus1", Cminus1, DB);
    chk("enc_d_out", d_out, DB);
    chk("enc_first", first_block, 64'h0);

    // Backpressure
    start_msg(OP_CBC, DIR_DEC, IV2);
    ct_valid = 1'b1; ct_in = C1; cycle();
    d_out_ready = 1'b0; core_valid = 1'b1; core_out = X1; ct_in = C2;
    cycle();
    ct_in = C3; core_out = X2;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_core_ready_%0d", i), core_ready, 64'h0);
      cycle();
      chk($sformatf("bp_hold_%0d", i), d_out, X1 ^ IV2);
    end
    chk("bp_full", ct_ready, 64'h0);
    ct_valid = 1'b0; d_out_ready = 1'b1;
    cycle();
    chk("bp_drain_d2", d_out, X2 ^ C1);
    core_out = X3; cycle();
    chk("bp_drain_d3", d_out, X3 ^ C2);
    core_valid = 1'b0;
    ct_valid = 1'b1; ct_in = C4; cycle();
    ct_valid = 1'b0;

    // msg_start mid-message: flush FIFO and chaining, new IV
    start_msg(OP_CBC, DIR_DEC, IV3);
    chk("ms_first", first_block, 64'h1);
    ct_valid = 1'b1; ct_in = D1; cycle();
    ct_valid = 1'b0;
    chk("ms_flushed_ready", ct_ready, 64'h1);
    core_valid = 1'b1; core_out = Y1; cycle();
    chk("ms_new_iv", d_out, Y1 ^ IV3);
    core_out = Y2; cycle();
    chk("ms_chain_d1", d_out, Y2 ^ D1);
    core_out = Y3; cycle();
    chk("empty_pop_zero", d_out, Y3);
    core_valid = 1'b0; cycle();
    chk("empty_pop_ptrs", ct_ready, 64'h1);

    // Asynchronous reset with two FIFO entries and a pending output
    start_msg(OP_CBC, DIR_DEC, IV1);
    ct_valid = 1'b1; ct_in = C1; cycle();
    ct_in = C2; cycle();
    d_out_ready = 1'b0; core_valid = 1'b1; core_out = X1; ct_in = C3;
    cycle();
    core_valid = 1'b0; ct_valid = 1'b0;
    chk("pre_rst_valid", d_out_valid, 64'h1);
    chk("pre_rst_full", ct_ready, 64'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_d_out", d_out, 64'h0);
    chk("arst_valid", d_out_valid, 64'h0);
    chk("arst_cminus1", Cminus1, 64'h0);
    chk("arst_first", first_block, 64'h1);
    chk("arst_ct_ready", ct_ready, 64'h1);
    @(posedge clk); #1;
    rst_n = 1'b1; d_out_ready = 1'b1;
    ct_valid = 1'b1; ct_in = C1; cycle();
    chk("post_rst_one", ct_ready, 64'h1);
    ct_in = C2; cycle();
    ct_valid = 1'b0;
    chk("post_rst_two", ct_ready, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
